seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 8000, clk cycles per digit slot; legal range is BLANK_CYC+1 to 65535.
REQ-002 Parameter BLANK_CYC, default 16, anode-off cycles at the start of each slot (anti-ghosting).
REQ-003 Parameter LZ_SUPPRESS, default 1, enables blanking of the t_10s digit when it is zero.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 t_10ms, t_100ms, t_1s, t_10s  input  4 each  BCD digits from the stopwatch counter.
REQ-007 seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-008 dp  output  1  decimal point, active-low.
REQ-009 an  output  4  digit anodes, active-low; an[0]=t_10ms, an[1]=t_100ms, an[2]=t_1s, an[3]=t_10s.
REQ-010 frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-011 A slot counter SHALL count 0..SCAN_DIV-1 and wrap to 0; a 2-bit digit index SHALL advance 0->1->2->3->0 on each wrap.
REQ-012 Snapshot: when slot counter=0 and index=0, all four inputs SHALL be latched together; the display SHALL use only the snapshot, so there is no tearing within a frame.
REQ-013 FSM states are BLANK and DRIVE; BLANK holds for slot counts 0..BLANK_CYC-1, then DRIVE holds for BLANK_CYC..SCAN_DIV-1; BLANK is re-entered at every slot wrap.
REQ-014 In BLANK, an SHALL be 4'b1111, seg SHALL be 7'b1111111, and dp SHALL be 1.
REQ-015 In DRIVE, exactly one an bit (the current index) SHALL be 0, and seg/dp SHALL show the snapshot digit for that index.
REQ-016 seg, dp, and an SHALL be registered, giving exactly one clk of latency from the slot-counter state to the outputs.
REQ-017 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Any snapshot nibble 10..15 SHALL display a dash (7'b0111111); this takes priority over suppression.
REQ-019 dp SHALL be 0 only while index 2 is in DRIVE, giving the format "SS.hh".
REQ-020 When LZ_SUPPRESS=1 and snapshot t_10s=0, index 3 SHALL keep an[3]=1 during DRIVE; t_1s is never suppressed.
REQ-021 frame_done SHALL be 1 for exactly the one (registered) cycle following the cycle where index=3 and the slot counter=SCAN_DIV-1.
REQ-022 Input changes during a frame SHALL have no effect until the next snapshot.
REQ-023 The first snapshot after reset release SHALL occur on the first clk edge with rst low.

Reset
REQ-024 While rst=1: slot counter=0, index=0, snapshot=0, FSM=BLANK, an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
REQ-025 rst asserted mid-slot or mid-frame SHALL force the REQ-024 values asynchronously, with no partial pulse on frame_done.

Verification (SCAN_DIV=8, BLANK_CYC=2, unless stated)
REQ-026 Inputs 1,2,3,4 (10s..10ms) after reset:
- per slot, an is 1111 for 2 cycles then low for 6 cycles;
- the sequence is an=1110 seg=0011001, then 1101/0110000, then 1011/0100100 with dp=0, then 0111/1111001;
- frame_done pulses once every 32 cycles.
REQ-027 t_10s=0, LZ_SUPPRESS=1: an[3] stays 1 throughout slot 3 and dp behaviour is unchanged; with LZ_SUPPRESS=0, slot 3 shows seg=1000000.
REQ-028 t_100ms=4'hC: slot 1 shows seg=0111111; t_10s=4'hF with LZ_SUPPRESS=1 shows a dash, not a blank.
REQ-029 Change t_10ms from 4 to 7 during slot 2: the rest of the frame is unchanged and the next frame's slot 0 shows seg=1111000.
REQ-030 Assert rst for 3 cycles mid-DRIVE of slot 2:
- outputs go to reset values in the same cycle;
- after release, the sequence restarts at slot 0 BLANK with a new snapshot;
- the first frame_done arrives 32 cycles later.
REQ-031 Defaults (SCAN_DIV=8000) with a 32 MHz clk: frame period is 32000 cycles (1 kHz refresh), and no two an bits are ever low simultaneously over 10 frames.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver for a stopwatch display.
// Each frame scans four slots, t_10ms first and t_10s last. Every slot opens
// with a short all-off window so the previous digit cannot ghost. The inputs
// are snapshotted once per frame, so a frame never mixes old and new digits.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV    = 8000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] t_10ms,
  input  logic [3:0] t_100ms,
  input  logic [3:0] t_1s,
  input  logic [3:0] t_10s,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {StBlank, StDrive} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_next;
  logic [1:0]      idx_q;
  logic [15:0]     snap_q;
  logic            cnt_last;
  logic [3:0]      digit;
  logic [6:0]      digit_seg;
  logic            suppress;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    r = 7'b0111111;
    case (v)
      4'd0: r = 7'b1000000;
      4'd1: r = 7'b1111001;
      4'd2: r = 7'b0100100;
      4'd3: r = 7'b0110000;
      4'd4: r = 7'b0011001;
      4'd5: r = 7'b0010010;
      4'd6: r = 7'b0000010;
      4'd7: r = 7'b1111000;
      4'd8: r = 7'b0000000;
      4'd9: r = 7'b0010000;
      default: r = 7'b0111111;
    endcase
    return r;
  endfunction

  // Slot counter wrap and the snapshot digit selected by the current index.
  always_comb begin
    cnt_last = (cnt_q == CntW'(SCAN_DIV - 1));
    cnt_next = cnt_last ? '0 : cnt_q + 1'b1;
    digit    = 4'd0;
    case (idx_q)
      2'd0: digit = snap_q[3:0];
      2'd1: digit = snap_q[7:4];
      2'd2: digit = snap_q[11:8];
      default: digit = snap_q[15:12];
    endcase
    digit_seg = decode(digit);
    // A dash (nibble >= 10) is never suppressed because only zero qualifies.
    suppress  = LZ_SUPPRESS && (idx_q == 2'd3) && (digit == 4'd0);
  end

  // Scan FSM: counters, per-frame snapshot, phase state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBlank;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      snap_q     <= 16'h0000;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      an         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      if (cnt_last) begin
        idx_q <= idx_q + 2'd1;
      end
      if ((cnt_q == '0) && (idx_q == 2'd0)) begin
        snap_q <= {t_10s, t_1s, t_100ms, t_10ms};
      end
      // state_q always describes the phase of the counter value it sits beside.
      state_q <= (32'(cnt_next) < BLANK_CYC) ? StBlank : StDrive;

      frame_done <= (idx_q == 2'd3) && cnt_last;

      if (state_q == StDrive) begin
        dp <= (idx_q != 2'd2);
        if (suppress) begin
          an  <= 4'b1111;
          seg <= 7'b1111111;
        end else begin
          an  <= ~(4'b0001 << idx_q);
          seg <= digit_seg;
        end
      end else begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (leading-zero suppression on and
// off) compared every cycle against an arithmetic frame-timing model, plus
// literal expectations for the documented display sequences.
module tb_seg7_scan_driver;

  localparam int D = 8;
  localparam int B = 2;
  localparam int F = 4 * D;
  localparam logic [12:0] RstOut = {1'b0, 4'hF, 1'b1, 7'h7F};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d10ms, d100ms, d1s, d10s;
  logic [6:0] seg_l, seg_n;
  logic       dp_l, dp_n, fd_l, fd_n;
  logic [3:0] an_l, an_n;

  int errors = 0;
  int checks = 0;
  int e_cur  = 0;
  bit cmp_en = 1'b0;

  seg7_scan_driver #(.SCAN_DIV(D), .BLANK_CYC(B), .LZ_SUPPRESS(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .t_10ms(d10ms), .t_100ms(d100ms), .t_1s(d1s), .t_10s(d10s),
    .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l)
  );

  seg7_scan_driver #(.SCAN_DIV(D), .BLANK_CYC(B), .LZ_SUPPRESS(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .t_10ms(d10ms), .t_100ms(d100ms), .t_1s(d1s), .t_10s(d10s),
    .seg(seg_n), .dp(dp_n), .an(an_n), .frame_done(fd_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (v > 4'd9) ? 7'h3F : tbl[v];
  endfunction

  // Expected {frame_done, an, dp, seg} for the output registered from state t.
  function automatic logic [12:0] model(input int t, input logic [15:0] s, input bit lz);
    int         cnt, idx;
    logic [3:0] dig, a;
    logic [6:0] sg;
    logic       fd, p;
    cnt = t % D;
    idx = (t / D) % 4;
    fd  = ((t % F) == F - 1);
    if (cnt < B) return {fd, 4'hF, 1'b1, 7'h7F};
    dig = s[idx*4 +: 4];
    p   = (idx == 2) ? 1'b0 : 1'b1;
    if (lz && idx == 3 && dig == 4'd0) begin
      a  = 4'hF;
      sg = 7'h7F;
    end else begin
      a  = 4'hF;
      a[idx] = 1'b0;
      sg = dec(dig);
    end
    return {fd, a, p, sg};
  endfunction

  // Reference timeline: n edges since release; snapshot every F edges.
  int          n;
  int          t_q;
  logic [15:0] snap, disp_q;
  bit          valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n     <= 0;
      valid <= 1'b0;
      snap  <= 16'h0;
    end else begin
      t_q    <= n;
      disp_q <= snap;
      valid  <= 1'b1;
      n      <= n + 1;
      if (n % F == 0) snap <= {d10s, d1s, d100ms, d10ms};
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [12:0] el, en;
    if (cmp_en) begin
      el = (rst || !valid) ? RstOut : model(t_q, disp_q, 1'b1);
      en = (rst || !valid) ? RstOut : model(t_q, disp_q, 1'b0);
      check("model_lz", {3'b0, fd_l, an_l, dp_l, seg_l}, {3'b0, el});
      check("model_nolz", {3'b0, fd_n, an_n, dp_n, seg_n}, {3'b0, en});
      check("an_onehot", 16'($countones(~an_l) <= 1), 16'd1);
    end
  end

  task automatic goto(input int target);
    repeat (target - e_cur) @(posedge clk);
    @(negedge clk);
    e_cur = target;
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s, input logic p);
    check({name, "_an"}, 16'(an_l), 16'(a));
    check({name, "_seg"}, 16'(seg_l), 16'(s));
    check({name, "_dp"}, 16'(dp_l), 16'(p));
  endtask

  initial begin
    d10ms = 4'd4; d100ms = 4'd3; d1s = 4'd2; d10s = 4'd1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset", 4'hF, 7'h7F, 1'b1);
    check("reset_fd", 16'(fd_l), 16'd0);
    rst = 1'b0;
    e_cur = 0;

    // Inputs 1,2,3,4 (10s..10ms): documented slot sequence.
    goto(1);  lit("s0_blank", 4'hF, 7'h7F, 1'b1);
    goto(5);  lit("s0_drive", 4'hE, 7'h19, 1'b1);
    goto(9);  lit("s1_blank", 4'hF, 7'h7F, 1'b1);
    goto(13); lit("s1_drive", 4'hD, 7'h30, 1'b1);
    goto(21); lit("s2_drive", 4'hB, 7'h24, 1'b0);
    goto(29); lit("s3_drive", 4'h7, 7'h79, 1'b1);
    goto(31); check("fd_early", 16'(fd_l), 16'd0);
    goto(32); check("fd_pulse", 16'(fd_l), 16'd1);
    goto(33); check("fd_once", 16'(fd_l), 16'd0);

    // t_10ms 4 -> 7 during slot 2: rest of frame unchanged, next frame shows 7.
    goto(50); d10ms = 4'd7;
    goto(61); lit("tear_s3", 4'h7, 7'h79, 1'b1);
    goto(69); lit("next_s0", 4'hE, 7'h78, 1'b1);

    // t_10s = 0: suppressed on one instance, shown as 0 on the other.
    d10s = 4'd0;
    goto(117); lit("lz_s2", 4'hB, 7'h24, 1'b0);
    goto(125);
    lit("lz_s3", 4'hF, 7'h7F, 1'b1);
    check("nolz_s3_an", 16'(an_n), 16'h7);
    check("nolz_s3_seg", 16'(seg_n), 16'h40);

    // Non-BCD nibbles show a dash; dash beats suppression.
    d100ms = 4'hC; d10s = 4'hF;
    goto(141); lit("dash_s1", 4'hD, 7'h3F, 1'b1);
    goto(157); lit("dash_s3", 4'h7, 7'h3F, 1'b1);

    // Reset mid-DRIVE of slot 2 acts asynchronously and restarts the frame.
    goto(181); lit("pre_rst", 4'hB, 7'h24, 1'b0);
    d10ms = 4'd5;
    #2 rst = 1'b1;
    #1 lit("async_rst", 4'hF, 7'h7F, 1'b1);
    check("async_rst_fd", 16'(fd_l), 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e_cur = 0;
    goto(1);  lit("rst_s0_blank", 4'hF, 7'h7F, 1'b1);
    goto(5);  lit("rst_s0_drive", 4'hE, 7'h12, 1'b1);
    goto(31); check("rst_fd_early", 16'(fd_l), 16'd0);
    goto(32); check("rst_fd_pulse", 16'(fd_l), 16'd1);

    // Randomized inputs and occasional resets, checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        d10ms  = 4'($urandom_range(15));
        d100ms = 4'($urandom_range(15));
        d1s    = 4'($urandom_range(15));
        d10s   = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
      end
      if (!rst && $urandom_range(499) == 0) begin
        #2 rst = 1'b1;
      end else if (rst && $urandom_range(2) == 0) begin
        rst = 1'b0;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * F) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
